// File: rtl/ro_buffer_pkg.sv
// ro_buffer_pkg: shared sizes, ID/data types and instruction-kind encodings
// for the reorder buffer and its query ports.
// Ports: none (package). Optional feature macro: RO_BUFFER_BYPASS_EN.
package ro_buffer_pkg;

  localparam int ROB_SIZE = 16;
  localparam int ID_W     = 5;
  localparam int XLEN     = 32;

  typedef logic [ID_W-1:0] rob_id_t;
  typedef logic [XLEN-1:0] reg_t;

  typedef enum logic [1:0] {
    KIND_REG    = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_STORE  = 2'd2,
    KIND_JUMP   = 2'd3
  } kind_t;

  // IDs run 1..ROB_SIZE; 0 is reserved for "none", so wrap skips it.
  function automatic rob_id_t id_inc(input rob_id_t id);
    return (id == rob_id_t'(ROB_SIZE)) ? rob_id_t'(1) : id + rob_id_t'(1);
  endfunction

endpackage

// File: rtl/ro_buffer_if.sv
// ro_buffer_if: bundles the issuer, writeback-bus, commit and flush signals
// of the reorder buffer. slave = the ROB itself, master = its environment.
// Ports: rdy, issue (valid/kind/rd/pred_pc), next_id/full, qj/qk queries,
// rss/lsb writeback buses, reg-file/store commit, flush + correct_pc.
interface ro_buffer_if;
  import ro_buffer_pkg::*;

  logic        rdy;
  logic        valid_from_issuer;
  logic [1:0]  kind_from_issuer;
  logic [4:0]  rd_from_issuer;
  reg_t        pred_pc_from_issuer;
  rob_id_t     next_id_to_issuer;
  logic        is_ro_buffer_full;
  rob_id_t     qj_query;
  rob_id_t     qk_query;
  logic        qj_ready;
  logic        qk_ready;
  reg_t        qj_value;
  reg_t        qk_value;
  rob_id_t     dest_from_rss_bus;
  reg_t        value_from_rss_bus;
  reg_t        next_pc_from_rss_bus;
  rob_id_t     dest_from_lsb_bus;
  reg_t        value_from_lsb_bus;
  logic [4:0]  rd_to_reg_file;
  reg_t        value_to_reg_file;
  rob_id_t     dest_to_reg_file;
  rob_id_t     store_id_to_lsb;
  logic        reset_to_rob_bus;
  reg_t        correct_pc_to_fetcher;

  modport slave (
    input  rdy, valid_from_issuer, kind_from_issuer, rd_from_issuer,
           pred_pc_from_issuer, qj_query, qk_query,
           dest_from_rss_bus, value_from_rss_bus, next_pc_from_rss_bus,
           dest_from_lsb_bus, value_from_lsb_bus,
    output next_id_to_issuer, is_ro_buffer_full, qj_ready, qk_ready,
           qj_value, qk_value, rd_to_reg_file, value_to_reg_file,
           dest_to_reg_file, store_id_to_lsb, reset_to_rob_bus,
           correct_pc_to_fetcher
  );

  modport master (
    output rdy, valid_from_issuer, kind_from_issuer, rd_from_issuer,
           pred_pc_from_issuer, qj_query, qk_query,
           dest_from_rss_bus, value_from_rss_bus, next_pc_from_rss_bus,
           dest_from_lsb_bus, value_from_lsb_bus,
    input  next_id_to_issuer, is_ro_buffer_full, qj_ready, qk_ready,
           qj_value, qk_value, rd_to_reg_file, value_to_reg_file,
           dest_to_reg_file, store_id_to_lsb, reset_to_rob_bus,
           correct_pc_to_fetcher
  );

endinterface

// File: rtl/ro_buffer_query_port.sv
// rob_query_port: combinational operand lookup into the reorder buffer.
// Ports: query ID in; per-entry ok mask and values in; rss/lsb bus dest/value
// in (used only when RO_BUFFER_BYPASS_EN is defined); ready/value out.
module rob_query_port
  import ro_buffer_pkg::*;
(
  input  rob_id_t           query,
  input  logic [ROB_SIZE:1] ent_ok,
  input  reg_t              ent_value [1:ROB_SIZE],
  input  rob_id_t           rss_dest,
  input  reg_t              rss_value,
  input  rob_id_t           lsb_dest,
  input  reg_t              lsb_value,
  output logic              ready,
  output reg_t              value
);

  logic in_range;
  assign in_range = (query != '0) && (query <= rob_id_t'(ROB_SIZE));

  always_comb begin
    ready = 1'b0;
    value = '0;
    if (query == '0) begin
      // ID 0 names no producer: the operand is already available.
      ready = 1'b1;
    end else if (in_range && ent_ok[query]) begin
      ready = 1'b1;
      value = ent_value[query];
    end
`ifdef RO_BUFFER_BYPASS_EN
    // Bus dests are idle at 0 and query is non-zero here, so an equal dest
    // is a live writeback. rss is applied last so it wins a double match.
    if (query != '0) begin
      if (lsb_dest == query) begin
        ready = 1'b1;
        value = lsb_value;
      end
      if (rss_dest == query) begin
        ready = 1'b1;
        value = rss_value;
      end
    end
`endif
  end

`ifndef RO_BUFFER_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{rss_dest, rss_value, lsb_dest, lsb_value};
`endif

endmodule

// File: rtl/ro_buffer.sv
// ro_buffer: in-order retiring reorder buffer with mispredict flush.
// Ports: clk, rst (async active-high), bus (ro_buffer_if.slave): issue,
// rss/lsb writeback, qj/qk queries, reg-file/store commit, flush/correct_pc.
// Optional same-cycle bus bypass on queries: RO_BUFFER_BYPASS_EN.
module ro_buffer
  import ro_buffer_pkg::*;
(
  input logic        clk,
  input logic        rst,
  ro_buffer_if.slave bus
);

  logic [ROB_SIZE:1] busy;
  logic [ROB_SIZE:1] ready;
  kind_t             kind    [1:ROB_SIZE];
  logic [4:0]        rd      [1:ROB_SIZE];
  reg_t              value   [1:ROB_SIZE];
  reg_t              next_pc [1:ROB_SIZE];
  reg_t              pred_pc [1:ROB_SIZE];
  rob_id_t           head;
  rob_id_t           tail;
  rob_id_t           count;
  rob_id_t           count_next;
  // Set by a mispredict commit; the following enabled cycle wipes the buffer.
  logic              flush_pend;

  logic [4:0]        commit_rd;
  reg_t              commit_value;
  rob_id_t           commit_dest;
  rob_id_t           commit_store;
  logic              flush;
  reg_t              flush_pc;

  logic    active;
  logic    full;
  logic    do_issue;
  logic    head_commit;
  kind_t   head_kind;
  logic    mispredict;
  logic    writes_rd;
  rob_id_t rss_dest;
  rob_id_t lsb_dest;
  logic    rss_hit;
  logic    lsb_hit;

  assign active = bus.rdy && !flush_pend;
  assign full   = (count == rob_id_t'(ROB_SIZE));

  assign do_issue    = active && bus.valid_from_issuer && !full;
  assign head_commit = active && busy[head] && ready[head];
  assign head_kind   = kind[head];
  assign mispredict  = ((head_kind == KIND_BRANCH) || (head_kind == KIND_JUMP)) &&
                       (next_pc[head] != pred_pc[head]);
  assign writes_rd   = ((head_kind == KIND_REG) || (head_kind == KIND_JUMP)) &&
                       (rd[head] != 5'd0);

  // Bus dests are masked while frozen or flushing so neither the stored
  // state nor the query bypass sees them.
  assign rss_dest = active ? bus.dest_from_rss_bus : '0;
  assign lsb_dest = active ? bus.dest_from_lsb_bus : '0;
  assign rss_hit  = (rss_dest != '0) && (rss_dest <= rob_id_t'(ROB_SIZE)) && busy[rss_dest];
  assign lsb_hit  = (lsb_dest != '0) && (lsb_dest <= rob_id_t'(ROB_SIZE)) && busy[lsb_dest];

  always_comb begin
    count_next = count;
    if (do_issue && !head_commit)
      count_next = count + rob_id_t'(1);
    else if (!do_issue && head_commit)
      count_next = count - rob_id_t'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      ready      <= '0;
      head       <= rob_id_t'(1);
      tail       <= rob_id_t'(1);
      count      <= '0;
      flush_pend <= 1'b0;
      for (int i = 1; i <= ROB_SIZE; i++) begin
        kind[i]    <= KIND_REG;
        rd[i]      <= '0;
        value[i]   <= '0;
        next_pc[i] <= '0;
        pred_pc[i] <= '0;
      end
    end else if (bus.rdy) begin
      if (flush_pend) begin
        // Everything younger than the mispredicted instruction is wrong
        // path; any issue offered this cycle is dropped with it.
        busy       <= '0;
        ready      <= '0;
        head       <= rob_id_t'(1);
        tail       <= rob_id_t'(1);
        count      <= '0;
        flush_pend <= 1'b0;
      end else begin
        if (do_issue) begin
          busy[tail]    <= 1'b1;
          ready[tail]   <= 1'b0;
          kind[tail]    <= kind_t'(bus.kind_from_issuer);
          rd[tail]      <= bus.rd_from_issuer;
          pred_pc[tail] <= bus.pred_pc_from_issuer;
          tail          <= id_inc(tail);
        end
        if (lsb_hit) begin
          ready[lsb_dest] <= 1'b1;
          value[lsb_dest] <= bus.value_from_lsb_bus;
        end
        if (rss_hit) begin
          ready[rss_dest]   <= 1'b1;
          value[rss_dest]   <= bus.value_from_rss_bus;
          next_pc[rss_dest] <= bus.next_pc_from_rss_bus;
        end
        // Freeing the head comes last so it overrides a stray writeback.
        if (head_commit) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
          head        <= id_inc(head);
          if (mispredict)
            flush_pend <= 1'b1;
        end
        count <= count_next;
      end
    end
  end

  // Commit and flush outputs are single-cycle pulses; head_commit already
  // includes rdy, so a frozen cycle leaves them all at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_rd    <= '0;
      commit_value <= '0;
      commit_dest  <= '0;
      commit_store <= '0;
      flush        <= 1'b0;
      flush_pc     <= '0;
    end else begin
      commit_rd    <= '0;
      commit_value <= '0;
      commit_dest  <= '0;
      commit_store <= '0;
      flush        <= 1'b0;
      flush_pc     <= '0;
      if (head_commit) begin
        if (writes_rd) begin
          commit_rd    <= rd[head];
          commit_value <= value[head];
          commit_dest  <= head;
        end
        if (head_kind == KIND_STORE)
          commit_store <= head;
        if (mispredict) begin
          flush    <= 1'b1;
          flush_pc <= next_pc[head];
        end
      end
    end
  end

  assign bus.next_id_to_issuer     = tail;
  assign bus.is_ro_buffer_full     = full;
  assign bus.rd_to_reg_file        = commit_rd;
  assign bus.value_to_reg_file     = commit_value;
  assign bus.dest_to_reg_file      = commit_dest;
  assign bus.store_id_to_lsb       = commit_store;
  assign bus.reset_to_rob_bus      = flush;
  assign bus.correct_pc_to_fetcher = flush_pc;

  logic [ROB_SIZE:1] ent_ok;
  assign ent_ok = busy & ready;

  rob_query_port u_qj (
    .query     (bus.qj_query),
    .ent_ok    (ent_ok),
    .ent_value (value),
    .rss_dest  (rss_dest),
    .rss_value (bus.value_from_rss_bus),
    .lsb_dest  (lsb_dest),
    .lsb_value (bus.value_from_lsb_bus),
    .ready     (bus.qj_ready),
    .value     (bus.qj_value)
  );

  rob_query_port u_qk (
    .query     (bus.qk_query),
    .ent_ok    (ent_ok),
    .ent_value (value),
    .rss_dest  (rss_dest),
    .rss_value (bus.value_from_rss_bus),
    .lsb_dest  (lsb_dest),
    .lsb_value (bus.value_from_lsb_bus),
    .ready     (bus.qk_ready),
    .value     (bus.qk_value)
  );

endmodule

// File: tb/tb_ro_buffer.sv
// tb_ro_buffer: directed self-checking bench for ro_buffer.
// Ports: none; drives an ro_buffer_if instance and the clk/rst of the DUT.
// Honours RO_BUFFER_BYPASS_EN for same-cycle query expectations.
module tb_ro_buffer;
  import ro_buffer_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  ro_buffer_if bus ();

  ro_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.rdy                  = 1'b1;
    bus.valid_from_issuer    = 1'b0;
    bus.kind_from_issuer     = 2'd0;
    bus.rd_from_issuer       = 5'd0;
    bus.pred_pc_from_issuer  = '0;
    bus.qj_query             = '0;
    bus.qk_query             = '0;
    bus.dest_from_rss_bus    = '0;
    bus.value_from_rss_bus   = '0;
    bus.next_pc_from_rss_bus = '0;
    bus.dest_from_lsb_bus    = '0;
    bus.value_from_lsb_bus   = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic issue(input logic [1:0] k, input logic [4:0] r, input reg_t pc);
    bus.valid_from_issuer   = 1'b1;
    bus.kind_from_issuer    = k;
    bus.rd_from_issuer      = r;
    bus.pred_pc_from_issuer = pc;
    step();
    bus.valid_from_issuer   = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    total++; if (bus.next_id_to_issuer !== 5'd1) begin bad++; $display("FAIL reset_next_id: got %0d want 1", bus.next_id_to_issuer); end
    total++; if ({bus.is_ro_buffer_full, bus.reset_to_rob_bus, bus.rd_to_reg_file, bus.store_id_to_lsb, bus.dest_to_reg_file} !== 17'd0) begin bad++; $display("FAIL reset_flags: got full=%b flush=%b rd=%0d st=%0d dest=%0d want all 0", bus.is_ro_buffer_full, bus.reset_to_rob_bus, bus.rd_to_reg_file, bus.store_id_to_lsb, bus.dest_to_reg_file); end
    total++; if ({bus.value_to_reg_file, bus.correct_pc_to_fetcher} !== 64'd0) begin bad++; $display("FAIL reset_values: got val=%h pc=%h want 0", bus.value_to_reg_file, bus.correct_pc_to_fetcher); end
    total++; if (bus.qj_ready !== 1'b1 || bus.qj_value !== 32'd0) begin bad++; $display("FAIL query_id0: got rdy=%b val=%h want 1/0", bus.qj_ready, bus.qj_value); end
    rst = 1'b0;
    // Mid-stream: five busy entries, ID 1 committing when reset hits.
    for (int i = 1; i <= 5; i++) issue(2'd0, 5'(i), '0);
    total++; if (bus.next_id_to_issuer !== 5'd6) begin bad++; $display("FAIL pre_reset_next_id: got %0d want 6", bus.next_id_to_issuer); end
    bus.dest_from_rss_bus  = 5'd1;
    bus.value_from_rss_bus = 32'h77;
    step();
    bus.dest_from_rss_bus  = '0;
    step();
    total++; if (bus.rd_to_reg_file !== 5'd1) begin bad++; $display("FAIL pre_reset_commit: got rd=%0d want 1", bus.rd_to_reg_file); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.next_id_to_issuer !== 5'd1 || bus.is_ro_buffer_full !== 1'b0) begin bad++; $display("FAIL async_reset_ptr: got next_id=%0d full=%b want 1/0", bus.next_id_to_issuer, bus.is_ro_buffer_full); end
    total++; if (bus.rd_to_reg_file !== 5'd0 || bus.value_to_reg_file !== 32'd0 || bus.dest_to_reg_file !== 5'd0) begin bad++; $display("FAIL async_reset_commit: got rd=%0d val=%h dest=%0d want 0", bus.rd_to_reg_file, bus.value_to_reg_file, bus.dest_to_reg_file); end
    bus.qj_query = 5'd2;
    #1;
    total++; if (bus.qj_ready !== 1'b0) begin bad++; $display("FAIL async_reset_entry: got ready=%b want 0", bus.qj_ready); end
    bus.qj_query = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_fill_full();
    apply_reset();
    for (int i = 1; i <= 16; i++) issue(2'd0, 5'(i), '0);
    total++; if (bus.is_ro_buffer_full !== 1'b1 || bus.next_id_to_issuer !== 5'd1) begin bad++; $display("FAIL full_after16: got full=%b next_id=%0d want 1/1", bus.is_ro_buffer_full, bus.next_id_to_issuer); end
    issue(2'd0, 5'd17, '0);
    total++; if (bus.is_ro_buffer_full !== 1'b1 || bus.next_id_to_issuer !== 5'd1) begin bad++; $display("FAIL issue17_ignored: got full=%b next_id=%0d want 1/1", bus.is_ro_buffer_full, bus.next_id_to_issuer); end
    bus.dest_from_rss_bus  = 5'd1;
    bus.value_from_rss_bus = 32'h55;
    step();
    bus.dest_from_rss_bus  = '0;
    total++; if (bus.rd_to_reg_file !== 5'd0) begin bad++; $display("FAIL commit_not_early: got rd=%0d want 0", bus.rd_to_reg_file); end
    step();
    total++; if (bus.rd_to_reg_file !== 5'd1 || bus.value_to_reg_file !== 32'h55 || bus.dest_to_reg_file !== 5'd1) begin bad++; $display("FAIL commit_id1: got rd=%0d val=%h dest=%0d want 1/55/1", bus.rd_to_reg_file, bus.value_to_reg_file, bus.dest_to_reg_file); end
    total++; if (bus.is_ro_buffer_full !== 1'b0) begin bad++; $display("FAIL full_after_commit: got %b want 0", bus.is_ro_buffer_full); end
    step();
    total++; if (bus.rd_to_reg_file !== 5'd0 || bus.dest_to_reg_file !== 5'd0) begin bad++; $display("FAIL commit_pulse: got rd=%0d dest=%0d want 0", bus.rd_to_reg_file, bus.dest_to_reg_file); end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      logic [4:0] exp_id;
      exp_id = 5'(i % 16 + 1);
      total++; if (bus.next_id_to_issuer !== exp_id) begin bad++; $display("FAIL wrap_next_id[%0d]: got %0d want %0d", i, bus.next_id_to_issuer, exp_id); end
      issue(2'd0, 5'd1, '0);
      bus.dest_from_rss_bus  = exp_id;
      bus.value_from_rss_bus = 32'h1000 + 32'(i);
      step();
      bus.dest_from_rss_bus  = '0;
      step();
      total++; if (bus.dest_to_reg_file !== exp_id || bus.value_to_reg_file !== 32'h1000 + 32'(i)) begin bad++; $display("FAIL wrap_commit[%0d]: got dest=%0d val=%h want %0d/%h", i, bus.dest_to_reg_file, bus.value_to_reg_file, exp_id, 32'h1000 + 32'(i)); end
    end
    total++; if (bus.next_id_to_issuer !== 5'd5) begin bad++; $display("FAIL wrap_final_id: got %0d want 5", bus.next_id_to_issuer); end
  endtask

  task automatic test_mispredict();
    apply_reset();
    issue(2'd0, 5'd1, '0);
    issue(2'd0, 5'd2, '0);
    issue(2'd1, 5'd3, 32'h100);
    issue(2'd0, 5'd4, '0);
    issue(2'd0, 5'd5, '0);
    bus.dest_from_rss_bus = 5'd1; bus.value_from_rss_bus = 32'h11;
    step();
    total++; if (bus.rd_to_reg_file !== 5'd0) begin bad++; $display("FAIL mp_w1: got rd=%0d want 0", bus.rd_to_reg_file); end
    bus.dest_from_rss_bus = 5'd2; bus.value_from_rss_bus = 32'h22;
    step();
    total++; if (bus.dest_to_reg_file !== 5'd1 || bus.value_to_reg_file !== 32'h11) begin bad++; $display("FAIL mp_commit1: got dest=%0d val=%h want 1/11", bus.dest_to_reg_file, bus.value_to_reg_file); end
    bus.dest_from_rss_bus = 5'd3; bus.value_from_rss_bus = 32'h0; bus.next_pc_from_rss_bus = 32'h104;
    step();
    total++; if (bus.dest_to_reg_file !== 5'd2 || bus.value_to_reg_file !== 32'h22 || bus.reset_to_rob_bus !== 1'b0) begin bad++; $display("FAIL mp_commit2: got dest=%0d val=%h flush=%b want 2/22/0", bus.dest_to_reg_file, bus.value_to_reg_file, bus.reset_to_rob_bus); end
    bus.dest_from_rss_bus = 5'd4; bus.value_from_rss_bus = 32'h44; bus.next_pc_from_rss_bus = 32'h0;
    step();
    total++; if (bus.reset_to_rob_bus !== 1'b1 || bus.correct_pc_to_fetcher !== 32'h104) begin bad++; $display("FAIL mp_flush: got flush=%b pc=%h want 1/104", bus.reset_to_rob_bus, bus.correct_pc_to_fetcher); end
    total++; if (bus.rd_to_reg_file !== 5'd0) begin bad++; $display("FAIL mp_branch_no_rd: got rd=%0d want 0", bus.rd_to_reg_file); end
    // Issue offered in the flush-clear cycle must be dropped.
    bus.dest_from_rss_bus = '0;
    bus.valid_from_issuer = 1'b1; bus.kind_from_issuer = 2'd0; bus.rd_from_issuer = 5'd7;
    bus.qj_query = 5'd4;
    step();
    bus.valid_from_issuer = 1'b0;
    total++; if (bus.reset_to_rob_bus !== 1'b0 || bus.correct_pc_to_fetcher !== 32'd0) begin bad++; $display("FAIL mp_flush_pulse: got flush=%b pc=%h want 0/0", bus.reset_to_rob_bus, bus.correct_pc_to_fetcher); end
    total++; if (bus.next_id_to_issuer !== 5'd1 || bus.is_ro_buffer_full !== 1'b0) begin bad++; $display("FAIL mp_cleared: got next_id=%0d full=%b want 1/0", bus.next_id_to_issuer, bus.is_ro_buffer_full); end
    total++; if (bus.qj_ready !== 1'b0 || bus.rd_to_reg_file !== 5'd0) begin bad++; $display("FAIL mp_discard4: got ready=%b rd=%0d want 0/0", bus.qj_ready, bus.rd_to_reg_file); end
    bus.qj_query = '0;
  endtask

  task automatic test_dual_writeback();
    apply_reset();
    for (int i = 1; i <= 6; i++) issue(2'd0, 5'(i), '0);
    bus.dest_from_rss_bus  = 5'd2; bus.value_from_rss_bus = 32'hAA;
    bus.dest_from_lsb_bus  = 5'd5; bus.value_from_lsb_bus = 32'hBB;
    bus.qj_query = 5'd2;
    bus.qk_query = 5'd5;
    #1;
`ifdef RO_BUFFER_BYPASS_EN
    total++; if (bus.qj_ready !== 1'b1 || bus.qj_value !== 32'hAA) begin bad++; $display("FAIL bypass_qj: got rdy=%b val=%h want 1/AA", bus.qj_ready, bus.qj_value); end
    total++; if (bus.qk_ready !== 1'b1 || bus.qk_value !== 32'hBB) begin bad++; $display("FAIL bypass_qk: got rdy=%b val=%h want 1/BB", bus.qk_ready, bus.qk_value); end
`else
    total++; if (bus.qj_ready !== 1'b0) begin bad++; $display("FAIL nobypass_qj: got rdy=%b want 0", bus.qj_ready); end
    total++; if (bus.qk_ready !== 1'b0) begin bad++; $display("FAIL nobypass_qk: got rdy=%b want 0", bus.qk_ready); end
`endif
    step();
    bus.dest_from_rss_bus = '0;
    bus.dest_from_lsb_bus = '0;
    #1;
    total++; if (bus.qj_ready !== 1'b1 || bus.qj_value !== 32'hAA) begin bad++; $display("FAIL dual_qj: got rdy=%b val=%h want 1/AA", bus.qj_ready, bus.qj_value); end
    total++; if (bus.qk_ready !== 1'b1 || bus.qk_value !== 32'hBB) begin bad++; $display("FAIL dual_qk: got rdy=%b val=%h want 1/BB", bus.qk_ready, bus.qk_value); end
    bus.qj_query = 5'd1;
    step();
    total++; if (bus.qj_ready !== 1'b0 || bus.rd_to_reg_file !== 5'd0) begin bad++; $display("FAIL dual_head_wait: got ready=%b rd=%0d want 0/0", bus.qj_ready, bus.rd_to_reg_file); end
    bus.qj_query = '0;
    bus.qk_query = '0;
  endtask

  task automatic test_store_rdy();
    apply_reset();
    issue(2'd2, 5'd9, '0);
    issue(2'd0, 5'd2, '0);
    bus.dest_from_lsb_bus = 5'd1; bus.value_from_lsb_bus = 32'h0;
    bus.dest_from_rss_bus = 5'd2; bus.value_from_rss_bus = 32'h22;
    step();
    bus.dest_from_lsb_bus = '0;
    bus.dest_from_rss_bus = '0;
    bus.rdy = 1'b0;
    bus.valid_from_issuer = 1'b1; bus.kind_from_issuer = 2'd0; bus.rd_from_issuer = 5'd4;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (bus.store_id_to_lsb !== 5'd0 || bus.rd_to_reg_file !== 5'd0 || bus.next_id_to_issuer !== 5'd3) begin bad++; $display("FAIL rdy_low_freeze[%0d]: got st=%0d rd=%0d next_id=%0d want 0/0/3", i, bus.store_id_to_lsb, bus.rd_to_reg_file, bus.next_id_to_issuer); end
    end
    bus.rdy = 1'b1;
    bus.valid_from_issuer = 1'b0;
    step();
    total++; if (bus.store_id_to_lsb !== 5'd1 || bus.rd_to_reg_file !== 5'd0) begin bad++; $display("FAIL store_commit: got st=%0d rd=%0d want 1/0", bus.store_id_to_lsb, bus.rd_to_reg_file); end
    step();
    total++; if (bus.store_id_to_lsb !== 5'd0 || bus.rd_to_reg_file !== 5'd2 || bus.value_to_reg_file !== 32'h22 || bus.dest_to_reg_file !== 5'd2) begin bad++; $display("FAIL after_store: got st=%0d rd=%0d val=%h dest=%0d want 0/2/22/2", bus.store_id_to_lsb, bus.rd_to_reg_file, bus.value_to_reg_file, bus.dest_to_reg_file); end
    bus.qj_query = 5'd2;
    step();
    total++; if (bus.rd_to_reg_file !== 5'd0 || bus.qj_ready !== 1'b0 || bus.next_id_to_issuer !== 5'd3) begin bad++; $display("FAIL drained: got rd=%0d ready=%b next_id=%0d want 0/0/3", bus.rd_to_reg_file, bus.qj_ready, bus.next_id_to_issuer); end
    bus.qj_query = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    test_reset();
    test_fill_full();
    test_wrap();
    test_mispredict();
    test_dual_writeback();
    test_store_rdy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
